// File: rtl/darkriscv_pkg.sv
// Shared types and constants for the darkriscv data-bus arbiter.
package darkriscv_pkg;

  typedef enum logic {
    DBUS_IDLE,
    DBUS_BUSY
  } dbus_state_t;

  // Read data returned to a master whose access was aborted by the timeout.
  localparam logic [31:0] DBUS_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/darkriscv_rr_arb.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping modulo NM.
module darkriscv_rr_arb
  import darkriscv_pkg::*;
#(
  parameter int unsigned NM = 2,
  parameter int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);

  int unsigned pos;
  logic        found;

  // Scan NM slots starting at the pointer; the first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NM; k++) begin
      pos = (32'(ptr_i) + k) % NM;
      if (!found && req_i[IW'(pos)]) begin
        found             = 1'b1;
        gnt_o[IW'(pos)]   = 1'b1;
        idx_o             = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/darkriscv_dbus_arbiter.sv
// Round-robin arbiter sharing one darkriscv data-bus slave among NM masters,
// with wait-state forwarding and an optional per-access timeout.
module darkriscv_dbus_arbiter
  import darkriscv_pkg::*;
#(
  parameter int unsigned NM  = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 0
) (
  input  logic           CLK,
  input  logic           RES,
  input  logic [NM-1:0]    M_DAS,
  input  logic [NM-1:0]    M_DRD,
  input  logic [NM-1:0]    M_DWR,
  input  logic [NM*AW-1:0] M_DADDR,
  input  logic [NM*DW-1:0] M_DATAO,
  input  logic [NM*3-1:0]  M_DLEN,
  output logic [DW-1:0]    M_DATAI,
  output logic [NM-1:0]    M_HLT,
  output logic           S_DAS,
  output logic           S_DRD,
  output logic           S_DWR,
  output logic [AW-1:0]  S_DADDR,
  output logic [DW-1:0]  S_DATAO,
  output logic [2:0]     S_DLEN,
  input  logic [DW-1:0]  S_DATAI,
  input  logic           S_HLT,
  output logic [NM-1:0]  TMO_ERR,
  output logic [NM-1:0]  GNT
);

  localparam int unsigned IW      = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW      = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int unsigned TmoLast = (TMO > 0) ? TMO - 1 : 0;

  dbus_state_t   state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NM-1:0] tmo_err_q, tmo_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NM-1:0] arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          busy, das_g, abort, done, complete;

  darkriscv_rr_arb #(
    .NM (NM),
    .IW (IW)
  ) u_rr_arb (
    .req_i (M_DAS),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Access status of the granted master; abort fires on the last allowed wait cycle.
  always_comb begin
    busy     = (state_q == DBUS_BUSY);
    das_g    = busy & M_DAS[gidx_q];
    abort    = (TMO > 0) & das_g & S_HLT & (cnt_q == CW'(TmoLast));
    done     = ~S_HLT | abort;
    // A dropped request also ends the access.
    complete = busy & (~das_g | done);
  end

  // Slave-side mux and master-side responses.
  always_comb begin
    S_DAS   = das_g & ~abort;
    S_DRD   = das_g & M_DRD[gidx_q] & ~abort;
    S_DWR   = das_g & M_DWR[gidx_q] & ~abort;
    S_DADDR = M_DADDR[gidx_q*AW +: AW];
    S_DATAO = M_DATAO[gidx_q*DW +: DW];
    S_DLEN  = M_DLEN[gidx_q*3 +: 3];
    M_DATAI = abort ? DW'(DBUS_ABORT_DATA) : S_DATAI;
    M_HLT   = M_DAS & ~({NM{busy & done}} & gnt_q);
    GNT     = gnt_q;
    TMO_ERR = tmo_err_q;
  end

  // Next-state: arbitrate in IDLE, wait for completion/abort in BUSY.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    tmo_err_d = tmo_err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      DBUS_IDLE: begin
        if (|M_DAS) begin
          state_d = DBUS_BUSY;
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          cnt_d   = '0;
        end
      end
      DBUS_BUSY: begin
        if (complete) begin
          state_d = DBUS_IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + 1'b1;
          if (abort) begin
            tmo_err_d[gidx_q] = 1'b1;
          end
        end else if ((TMO > 0) && S_HLT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DBUS_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q   <= DBUS_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      tmo_err_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      tmo_err_q <= tmo_err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_darkriscv_dbus_arbiter.sv
// Randomized bench for darkriscv_dbus_arbiter against a transaction-level reference model.
module tb_darkriscv_dbus_arbiter;

  localparam int unsigned NM  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;
  localparam logic [31:0] AbortData = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res;
  logic [NM-1:0]    m_das, m_drd, m_dwr;
  logic [NM*AW-1:0] m_daddr;
  logic [NM*DW-1:0] m_datao;
  logic [NM*3-1:0]  m_dlen;
  logic [DW-1:0]    m_datai;
  logic [NM-1:0]    m_hlt;
  logic             s_das, s_drd, s_dwr;
  logic [AW-1:0]    s_daddr;
  logic [DW-1:0]    s_datao;
  logic [2:0]       s_dlen;
  logic [DW-1:0]    s_datai;
  logic             s_hlt;
  logic [NM-1:0]    tmo_err, gnt;

  darkriscv_dbus_arbiter #(
    .NM  (NM),
    .AW  (AW),
    .DW  (DW),
    .TMO (TMO)
  ) dut (
    .CLK     (clk),
    .RES     (res),
    .M_DAS   (m_das),
    .M_DRD   (m_drd),
    .M_DWR   (m_dwr),
    .M_DADDR (m_daddr),
    .M_DATAO (m_datao),
    .M_DLEN  (m_dlen),
    .M_DATAI (m_datai),
    .M_HLT   (m_hlt),
    .S_DAS   (s_das),
    .S_DRD   (s_drd),
    .S_DWR   (s_dwr),
    .S_DADDR (s_daddr),
    .S_DATAO (s_datao),
    .S_DLEN  (s_dlen),
    .S_DATAI (s_datai),
    .S_HLT   (s_hlt),
    .TMO_ERR (tmo_err),
    .GNT     (gnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, where the round-robin resumes, wait cycles so far.
  bit            mdl_busy;
  int            mdl_owner, mdl_ptr, mdl_waits;
  bit [NM-1:0]   mdl_err;
  int            skipped [NM];
  int            aborts, wraps;
  logic [NM-1:0] last_done;

  task automatic mdl_reset();
    mdl_busy  = 0;
    mdl_owner = 0;
    mdl_ptr   = 0;
    mdl_waits = 0;
    mdl_err   = '0;
    for (int i = 0; i < NM; i++) skipped[i] = 0;
  endtask

  task automatic drive(input int cyc);
    int phase;
    phase = (cyc / 100) % 3;
    res   = (cyc < 3) ? 1'b0 : ($urandom_range(99) != 0);
    for (int i = 0; i < NM; i++) begin
      // A pending, unserved request is held; occasionally a master abandons it.
      if (!(m_das[i] && !last_done[i]) || $urandom_range(49) == 0) begin
        m_das[i]            = 1'($urandom_range(1));
        m_drd[i]            = 1'($urandom_range(1));
        m_dwr[i]            = ~m_drd[i];
        m_daddr[i*AW +: AW] = $urandom;
        m_datao[i*DW +: DW] = $urandom;
        m_dlen[i*3 +: 3]    = 3'($urandom_range(7));
      end
    end
    case (phase)
      0:       s_hlt = ($urandom_range(2) == 0);
      1:       s_hlt = ($urandom_range(11) != 0);
      default: s_hlt = 1'b0;
    endcase
    s_datai = $urandom;
  endtask

  task automatic eval_cycle(input int cyc);
    bit            das_g, abort, done;
    logic [NM-1:0] exp_hlt;
    logic [NM-1:0] exp_gnt;
    int            o;
    o       = mdl_owner;
    das_g   = mdl_busy && m_das[o];
    abort   = das_g && s_hlt && (mdl_waits == TMO - 1);
    done    = !s_hlt || abort;
    exp_gnt = '0;
    if (mdl_busy) exp_gnt[o] = 1'b1;
    for (int i = 0; i < NM; i++) exp_hlt[i] = m_das[i] && !(mdl_busy && i == o && done);

    if (cyc > 0) begin
      check_eq("m_hlt", m_hlt, exp_hlt);
      check_eq("gnt", gnt, exp_gnt);
      check_eq("tmo_err", tmo_err, mdl_err);
      check_eq("s_das", s_das, das_g && !abort);
      check_eq("s_drd", s_drd, das_g && m_drd[o] && !abort);
      check_eq("s_dwr", s_dwr, das_g && m_dwr[o] && !abort);
      if (das_g) begin
        check_eq("s_daddr", s_daddr, m_daddr[o*AW +: AW]);
        check_eq("s_datao", s_datao, m_datao[o*DW +: DW]);
        check_eq("s_dlen", s_dlen, m_dlen[o*3 +: 3]);
        if (done) check_eq("m_datai", m_datai, abort ? AbortData : s_datai);
      end
    end
    last_done = m_das & ~exp_hlt;

    if (!res) begin
      mdl_reset();
    end else if (!mdl_busy) begin
      if (|m_das) begin
        for (int k = 0; k < NM; k++) begin
          if (!mdl_busy && m_das[(mdl_ptr + k) % NM]) begin
            mdl_busy  = 1;
            mdl_owner = (mdl_ptr + k) % NM;
            if (mdl_ptr + k >= NM) wraps++;
          end
        end
        mdl_waits = 0;
        for (int j = 0; j < NM; j++) begin
          if (j != mdl_owner) skipped[j] = m_das[j] ? skipped[j] + 1 : 0;
        end
        if (cyc > 0) check_eq("fair", skipped[mdl_owner] <= NM - 1, 1);
        skipped[mdl_owner] = 0;
      end
    end else if (!das_g || done) begin
      mdl_busy = 0;
      mdl_ptr  = (o + 1) % NM;
      if (abort) begin
        mdl_err[o] = 1'b1;
        aborts++;
      end
    end else begin
      mdl_waits++;
    end
  endtask

  initial begin
    res       = 1'b0;
    m_das     = '0;
    m_drd     = '0;
    m_dwr     = '0;
    m_daddr   = '0;
    m_datao   = '0;
    m_dlen    = '0;
    s_datai   = '0;
    s_hlt     = 1'b0;
    last_done = '0;
    aborts    = 0;
    wraps     = 0;
    mdl_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      eval_cycle(cyc);
    end
    check_eq("abort_seen", aborts > 0, 1);
    check_eq("wrap_seen", wraps > 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
